// File: rtl/key_logic_unit.sv
// Debounced W-bit key operands -> AND/OR/XOR/XNOR selected by a mode key; KEY_LOGIC_UNIT_AUTO_CYCLE_EN adds idle mode auto-advance.
// Latency: raw key edge to result is 2+DEBOUNCE_CYCLES+1 cycles; there is no backpressure, and results are free-running registers.
module key_logic_unit #(
    parameter int W               = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int AUTO_PERIOD     = 50000000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [2*W-1:0] key_n,
    input  logic           mode_key_n,
    output logic [W-1:0]   result,
    output logic [1:0]     mode,
    output logic           result_valid
);
    localparam int NK = 2 * W + 1;
    localparam int MK = 2 * W;
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    if (W < 1 || W > 8 || DEBOUNCE_CYCLES < 2 || AUTO_PERIOD < 2) begin : g_param_check
        $error("key_logic_unit: illegal parameter value");
    end

    logic [NK-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [NK-1:0] dbn_q, dbn_d, accept;
    logic [CW-1:0] cnt_q [NK];
    logic [CW-1:0] cnt_d [NK];
    logic [1:0]    mode_q, mode_d;
    logic [W-1:0]  result_q, result_d;
    logic          result_valid_q, result_valid_d;
    logic          press, advance;

    always_comb begin
        sync1_d = {mode_key_n, key_n};
        sync2_d = sync1_q;
    end

    // Counter tracks how long the synchronised sample has disagreed with the accepted value.
    always_comb begin
        dbn_d  = dbn_q;
        accept = '0;
        for (int i = 0; i < NK; i++) begin
            cnt_d[i] = '0;
            if (~sync2_q[i] != dbn_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    dbn_d[i]  = ~sync2_q[i];
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = accept[MK] & dbn_d[MK];

`ifdef KEY_LOGIC_UNIT_AUTO_CYCLE_EN
    localparam int TW = $clog2(AUTO_PERIOD);
    logic [TW-1:0] timer_q, timer_d;
    logic          expire;

    // A press landing on the expiry cycle still yields a single advance.
    always_comb begin
        expire  = (timer_q == TW'(AUTO_PERIOD - 1));
        advance = press | expire;
        timer_d = ((|accept) || expire) ? '0 : timer_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) timer_q <= '0;
        else          timer_q <= timer_d;
    end
`else
    assign advance = press;
`endif

    always_comb begin
        mode_d = advance ? mode_q + 2'd1 : mode_q;
        case (mode_q)
            2'd0:    result_d = dbn_q[W-1:0] & dbn_q[2*W-1:W];
            2'd1:    result_d = dbn_q[W-1:0] | dbn_q[2*W-1:W];
            2'd2:    result_d = dbn_q[W-1:0] ^ dbn_q[2*W-1:W];
            default: result_d = ~(dbn_q[W-1:0] ^ dbn_q[2*W-1:W]);
        endcase
        result_valid_d = (result_d != result_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q        <= '1;
            sync2_q        <= '1;
            dbn_q          <= '0;
            mode_q         <= 2'd0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            dbn_q          <= dbn_d;
            mode_q         <= mode_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            for (int i = 0; i < NK; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign result       = result_q;
    assign mode         = mode_q;
    assign result_valid = result_valid_q;
endmodule

// File: tb/tb_key_logic_unit.sv
// Randomised and directed bench for key_logic_unit with an in-bench behavioural model.
// Model: pressed sample = inverted raw key from two edges ago; a key is accepted once its last D samples all disagree.
module tb_key_logic_unit;
    localparam int W  = 2;
    localparam int D  = 4;
    localparam int P  = 20;
    localparam int NK = 2 * W + 1;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [2*W-1:0] key_n = '1;
    logic           mode_key_n = 1'b1;
    logic [W-1:0]   result;
    logic [1:0]     mode;
    logic           result_valid;

    key_logic_unit #(.W(W), .DEBOUNCE_CYCLES(D), .AUTO_PERIOD(P)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_n        (key_n),
        .mode_key_n   (mode_key_n),
        .result       (result),
        .mode         (mode),
        .result_valid (result_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int vld_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] op(input logic [W-1:0] a, input logic [W-1:0] b, input int md);
        case (md)
            0:       return a & b;
            1:       return a | b;
            2:       return a ^ b;
            default: return ~(a ^ b);
        endcase
    endfunction

    // ---------------- behavioural model ----------------
    logic [NK-1:0] m_raw_prev1 = '1;
    logic [NK-1:0] m_raw_prev2 = '1;
    logic [D-1:0]  m_win [NK];
    logic [NK-1:0] m_dbn = '0;
    int            m_mode = 0;
    logic [W-1:0]  m_res = '0;
    logic          m_vld = 1'b0;
    int            m_cyc = 0;
    int            m_last_evt = 0;

    initial begin
        for (int k = 0; k < NK; k++) m_win[k] = '0;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_raw_prev1 = '1; m_raw_prev2 = '1; m_dbn = '0;
                m_mode = 0; m_res = '0; m_vld = 1'b0; m_cyc = 0; m_last_evt = 0;
                for (int k = 0; k < NK; k++) m_win[k] = '0;
            end else begin
                logic [W-1:0]  nres;
                logic [NK-1:0] samp;
                logic          any_tr, prs, adv;
                nres  = op(m_dbn[W-1:0], m_dbn[2*W-1:W], m_mode);
                m_vld = (nres != m_res);
                m_res = nres;
                samp  = ~m_raw_prev2;
                m_raw_prev2 = m_raw_prev1;
                m_raw_prev1 = {mode_key_n, key_n};
                any_tr = 1'b0;
                prs    = 1'b0;
                for (int k = 0; k < NK; k++) begin
                    m_win[k] = {m_win[k][D-2:0], samp[k]};
                    if (m_win[k] == {D{~m_dbn[k]}}) begin
                        m_dbn[k] = ~m_dbn[k];
                        any_tr   = 1'b1;
                        if (k == NK - 1 && m_dbn[k]) prs = 1'b1;
                    end
                end
                m_cyc++;
                adv = prs;
`ifdef KEY_LOGIC_UNIT_AUTO_CYCLE_EN
                if (m_cyc - m_last_evt == P) adv = 1'b1;
                if (any_tr || adv) m_last_evt = m_cyc;
`endif
                if (adv) m_mode = (m_mode + 1) % 4;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cyc_result", 32'(result), 32'(m_res));
            chk("cyc_mode", 32'(mode), 32'(m_mode));
            chk("cyc_valid", 32'(result_valid), 32'(m_vld));
            if (result_valid === 1'b1) vld_total++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_mode();
        mode_key_n = 1'b0; step(8);
        mode_key_n = 1'b1; step(8);
    endtask

    initial begin : driver
        int base;
        int old;
        logic [1:0] exp_mode [4];
        logic [1:0] exp_res [4];
        exp_mode = '{2'd1, 2'd2, 2'd3, 2'd0};
        exp_res  = '{2'b11, 2'b10, 2'b01, 2'b01};

        // Reset hold and release
        step(3);
        chk("rst_result", 32'(result), 0);
        chk("rst_mode", 32'(mode), 0);
        chk("rst_valid", 32'(result_valid), 0);
        reset_n = 1'b1;
        step(5);
        chk("post_rst_result", 32'(result), 0);
        chk("post_rst_mode", 32'(mode), 0);

`ifdef KEY_LOGIC_UNIT_AUTO_CYCLE_EN
        old = int'(mode);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (int'(mode) != old) break;
        end
        chk("auto_first_adv", 32'(mode), 32'((old + 1) % 4));
        old = int'(mode);
        edges(19);
        chk("auto_hold19", 32'(mode), 32'(old));
        edges(1);
        chk("auto_adv20", 32'(mode), 32'((old + 1) % 4));
        old = int'(mode);
        #1;
        edges(8); #1;
        key_n[0] = 1'b0;
        edges(25);
        chk("auto_restart_hold", 32'(mode), 32'(old));
        edges(1);
        chk("auto_restart_adv", 32'(mode), 32'((old + 1) % 4));
        #1;
        key_n = '1;
        step(10);
`else
        // Both operands fully pressed: seven-cycle latency and a single pulse
        base = vld_total;
        key_n = 4'b0000;
        edges(6);
        chk("lat_before", 32'(result), 0);
        edges(1);
        chk("lat_at7", 32'(result), 32'b11);
        chk("lat_valid", 32'(result_valid), 1);
        chk("model_pin_11", 32'(m_res), 32'b11);
        #1;
        step(3);
        chk("lat_pulses", 32'(vld_total - base), 1);
        key_n = 4'b0001;
        edges(6);
        chk("rel_before", 32'(result), 32'b11);
        edges(1);
        chk("rel_at7", 32'(result), 32'b10);
        #1;

        // Bounce on key_n[1]
        key_n = 4'b0011;
        step(10);
        chk("bounce_start", 32'(result), 0);
        key_n = 4'b0001; step(3);
        key_n = 4'b0011; step(1);
        key_n = 4'b0001;
        edges(6);
        chk("bounce_before", 32'(result), 0);
        edges(1);
        chk("bounce_at7", 32'(result), 32'b10);
        #1;

        // Mode cycling with A=01, B=11
        key_n = 4'b0010;
        step(10);
        chk("mode_and", 32'(result), 32'b01);
        for (int i = 0; i < 4; i++) begin
            press_mode();
            chk("mode_step", 32'(mode), 32'(exp_mode[i]));
            chk("mode_result", 32'(result), 32'(exp_res[i]));
        end
        chk("model_pin_mode", 32'(m_mode), 0);

        // A=10, B=10: AND->OR unchanged, OR->XOR clears
        key_n = 4'b0101;
        step(10);
        chk("same_and", 32'(result), 32'b10);
        base = vld_total;
        press_mode();
        chk("same_or_mode", 32'(mode), 1);
        chk("same_or_result", 32'(result), 32'b10);
        chk("same_or_pulses", 32'(vld_total - base), 0);
        base = vld_total;
        press_mode();
        chk("xor_mode", 32'(mode), 2);
        chk("xor_result", 32'(result), 0);
        chk("xor_pulses", 32'(vld_total - base), 1);

        // Asynchronous reset mid-run, between clock edges
        chk("prereset_result_nz", 32'(result == 2'b00 && mode == 2'd2), 1);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst_mode", 32'(mode), 0);
        chk("async_rst_result", 32'(result), 0);
        chk("async_rst_valid", 32'(result_valid), 0);
        key_n = '1;
        mode_key_n = 1'b1;
        step(2);
        reset_n = 1'b1;

        // Idle: no auto advance in the default build
        step(100);
        chk("idle_mode", 32'(mode), 0);
`endif

        // Randomised keys, including short bounces and mode presses
        for (int i = 0; i < 60; i++) begin
            key_n      = 4'($urandom);
            mode_key_n = 1'($urandom_range(0, 1));
            step($urandom_range(1, 12));
        end
        key_n = '1;
        mode_key_n = 1'b1;
        step(12);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
